regfile_port_arbiter: RTL and testbench
=======================================

// Module: regfile_port_arbiter
// PURPOSE
//  Shares the decode-stage register file between the pipeline and a debug requester (UART debugger).
//  The debug side can read through read port 1 or write through the single write port.
//  Pipeline writeback always has priority. A debug request starved for MAX_WAIT cycles forces a
//  pipeline stall: fetch/decode freeze and bubbles drain EX/MEM/WB, then the access is served.
//  Sits between decode_stage and register_file; stall_req feeds the hazard logic (PCWrite/FetchWrite/MakeBubble).
// PARAMETERS
//  MAX_WAIT      8  cycles a pending debug request waits before stall_req is raised (>=1)
//  DRAIN_CYCLES  3  stall cycles before a forced grant (EX, MEM, WB drained of writes)
// PORTS
//  clk            in   1   clock; all state updates on rising edge
//  rst            in   1   synchronous, active-high reset
//  wb_RegWrite    in   1   writeback stage writes the register file this cycle
//  wb_rd          in   5   writeback destination
//  wb_data        in   32  writeback data
//  dec_rs1        in   5   decode rs1 (instruction.rs1)
//  dec_rs1_used   in   1   decode needs read port 1 this cycle
//  dbg_req        in   1   debug request; held high until dbg_ack
//  dbg_we         in   1   1 = write, 0 = read; stable while dbg_req is high
//  dbg_addr       in   5   debug register index; stable while dbg_req is high
//  dbg_wdata      in   32  debug write data; stable while dbg_req is high
//  dbg_ack        out  1   one-cycle completion pulse (registered)
//  dbg_rdata      out  32  read result, valid while dbg_ack is high (registered)
//  rf_write_en    out  1   to register_file.write_en
//  rf_write_id    out  5   to register_file.write_id
//  rf_write_data  out  32  to register_file.write_data
//  rf_read1_id    out  5   to register_file.read1_id
//  rf_read1_data  in   32  from register_file.read1_data
//  stall_req      out  1   freeze PC/fetch and bubble decode (registered)
// BEHAVIOUR
//  Reset: state=IDLE; wait_cnt=0; drain_cnt=0; dbg_ack=0; dbg_rdata=0; stall_req=0.
//   Reset mid-request abandons it and drops stall_req next cycle. No ack is given.
//   The requester must re-issue.
//  port_free = dbg_we ? !wb_RegWrite : !dec_rs1_used.
//  grant (combinational) = dbg_req & (state in IDLE/WAIT/STALL)
//   & (port_free | (state==STALL & drain_cnt==DRAIN_CYCLES)).
//  FSM:
//   IDLE:  dbg_req & grant -> ACK.
//          dbg_req & !grant -> WAIT, wait_cnt=1.
//   WAIT:  grant -> ACK.
//          else wait_cnt==MAX_WAIT -> STALL, drain_cnt=0, stall_req<=1.
//          else wait_cnt++.
//   STALL: stall_req=1; drain_cnt++ (saturating at DRAIN_CYCLES).
//          grant -> ACK, stall_req<=0.
//   ACK:   dbg_ack=1 for exactly one cycle -> IDLE.
//          dbg_req is ignored in ACK, so back-to-back requests are spaced by >=1 idle cycle.
//  Write mux:
//   grant & dbg_we: rf_write_en = (dbg_addr!=0), id=dbg_addr, data=dbg_wdata.
//   Otherwise pass wb_RegWrite/wb_rd/wb_data through unchanged.
//   Writes to x0 still ack.
//  Read mux:
//   grant & !dbg_we: rf_read1_id=dbg_addr. Otherwise rf_read1_id=dec_rs1.
//  Read data, captured into dbg_rdata at the grant edge:
//   0 if dbg_addr==0.
//   wb_data if wb_RegWrite & wb_rd==dbg_addr (same-cycle bypass).
//   else rf_read1_data.
//  Latency: free port -> grant in the request cycle, dbg_ack one cycle later.
//  Worst case: MAX_WAIT+DRAIN_CYCLES+2 cycles.
//  dbg_req dropping before ack is a protocol violation: the FSM returns to IDLE, stall_req drops, no ack.
// TESTING
//  1 Debug write x5=0xDEADBEEF, wb idle:
//    rf_write_en=1/id=5 in the request cycle; dbg_ack the next cycle; stall_req stays 0.
//  2 Debug read x7 with dec_rs1_used=1 for 3 cycles, then 0:
//    rf_read1_id=7 on cycle 3; ack on cycle 4; no stall.
//  3 wb_RegWrite held 1 continuously, debug write x9:
//    stall_req rises after 8 wait cycles; grant after 3 drain cycles; ack next; stall_req falls with ack.
//  4 Debug read x3 while wb writes x3=0x1234 in the same cycle: dbg_rdata=0x00001234.
//  5 Debug write x0=0xFFFFFFFF: ack given, rf_write_en stays 0; subsequent read of x0 returns 0.
//  6 rst during STALL: next cycle stall_req=0, dbg_ack=0, state IDLE; a new request is served normally.

Source files
------------

// File: rtl/regfile_port_arbiter.sv
// Arbitrates register-file read port 1 and the write port between the pipeline and a debug requester.
// Pipeline traffic wins; a starved debug access raises stall_req, waits for the drain, then is forced through.
module regfile_port_arbiter #(
    parameter int unsigned MAX_WAIT     = 8,
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_RegWrite,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic [4:0]  dec_rs1,
    input  logic        dec_rs1_used,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [4:0]  dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [31:0] dbg_rdata,
    output logic        rf_write_en,
    output logic [4:0]  rf_write_id,
    output logic [31:0] rf_write_data,
    output logic [4:0]  rf_read1_id,
    input  logic [31:0] rf_read1_data,
    output logic        stall_req
);

    localparam int unsigned WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam int unsigned DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_STALL = 2'd2,
        ST_ACK   = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic [DW-1:0] drain_cnt_q, drain_cnt_d;
    logic          stall_req_q, stall_req_d;
    logic          dbg_ack_q, dbg_ack_d;
    logic [31:0]   dbg_rdata_q, dbg_rdata_d;

    logic port_free;
    logic drain_done;
    logic grant;

    always_comb begin
        port_free  = dbg_we ? !wb_RegWrite : !dec_rs1_used;
        drain_done = (state_q == ST_STALL) && (drain_cnt_q == DW'(DRAIN_CYCLES));
        grant      = dbg_req && (state_q != ST_ACK) && (port_free || drain_done);
    end

    // Port muxes: debug owns a port only in its grant cycle.
    always_comb begin
        rf_write_en   = wb_RegWrite;
        rf_write_id   = wb_rd;
        rf_write_data = wb_data;
        rf_read1_id   = dec_rs1;
        if (grant && dbg_we) begin
            rf_write_en   = (dbg_addr != 5'd0);
            rf_write_id   = dbg_addr;
            rf_write_data = dbg_wdata;
        end
        if (grant && !dbg_we) begin
            rf_read1_id = dbg_addr;
        end
    end

    // Next state; a request dropped before its ack returns to IDLE silently.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        drain_cnt_d = drain_cnt_q;
        stall_req_d = 1'b0;
        dbg_ack_d   = grant;
        dbg_rdata_d = dbg_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (dbg_req) begin
                    if (grant) begin
                        state_d = ST_ACK;
                    end else begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = WW'(1);
                    end
                end
            end
            ST_WAIT: begin
                if (!dbg_req) begin
                    state_d = ST_IDLE;
                end else if (grant) begin
                    state_d = ST_ACK;
                end else if (wait_cnt_q == WW'(MAX_WAIT)) begin
                    state_d     = ST_STALL;
                    drain_cnt_d = '0;
                    stall_req_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end
            end
            ST_STALL: begin
                if (!dbg_req) begin
                    state_d = ST_IDLE;
                end else if (grant) begin
                    state_d = ST_ACK;
                end else begin
                    stall_req_d = 1'b1;
                    if (!drain_done) begin
                        drain_cnt_d = drain_cnt_q + DW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_d == ST_IDLE || state_d == ST_ACK) begin
            wait_cnt_d  = '0;
            drain_cnt_d = '0;
        end
        // Zero register reads as zero, then same-cycle writeback bypass, then the array.
        if (grant && !dbg_we) begin
            if (dbg_addr == 5'd0) begin
                dbg_rdata_d = 32'd0;
            end else if (wb_RegWrite && (wb_rd == dbg_addr)) begin
                dbg_rdata_d = wb_data;
            end else begin
                dbg_rdata_d = rf_read1_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            drain_cnt_q <= '0;
            stall_req_q <= 1'b0;
            dbg_ack_q   <= 1'b0;
            dbg_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            stall_req_q <= stall_req_d;
            dbg_ack_q   <= dbg_ack_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    assign dbg_ack   = dbg_ack_q;
    assign dbg_rdata = dbg_rdata_q;
    assign stall_req = stall_req_q;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a behavioural register array on the rf ports.
module tb_regfile_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_RegWrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  dec_rs1;
    logic        dec_rs1_used;
    logic        dbg_req;
    logic        dbg_we;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        rf_write_en;
    logic [4:0]  rf_write_id;
    logic [31:0] rf_write_data;
    logic [4:0]  rf_read1_id;
    logic [31:0] rf_read1_data;
    logic        stall_req;

    int total = 0;
    int bad   = 0;

    logic [31:0] rf_mem [32];

    always #5 clk = ~clk;

    regfile_port_arbiter #(.MAX_WAIT(8), .DRAIN_CYCLES(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_RegWrite  (wb_RegWrite),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .dec_rs1      (dec_rs1),
        .dec_rs1_used (dec_rs1_used),
        .dbg_req      (dbg_req),
        .dbg_we       (dbg_we),
        .dbg_addr     (dbg_addr),
        .dbg_wdata    (dbg_wdata),
        .dbg_ack      (dbg_ack),
        .dbg_rdata    (dbg_rdata),
        .rf_write_en  (rf_write_en),
        .rf_write_id  (rf_write_id),
        .rf_write_data(rf_write_data),
        .rf_read1_id  (rf_read1_id),
        .rf_read1_data(rf_read1_data),
        .stall_req    (stall_req)
    );

    always @(posedge clk) begin
        if (rf_write_en) rf_mem[rf_write_id] <= rf_write_data;
    end
    assign rf_read1_data = rf_mem[rf_read1_id];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        wb_RegWrite  = 1'b0;
        wb_rd        = 5'd0;
        wb_data      = 32'd0;
        dec_rs1      = 5'd0;
        dec_rs1_used = 1'b0;
        dbg_req      = 1'b0;
        dbg_we       = 1'b0;
        dbg_addr     = 5'd0;
        dbg_wdata    = 32'd0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'd0;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        settle();
        check("reset_ack", 32'(dbg_ack), 32'd0);
        check("reset_stall", 32'(stall_req), 32'd0);
        check("reset_rdata", dbg_rdata, 32'd0);

        // Pass-through with no debug request; this also seeds x7.
        wb_RegWrite = 1'b1; wb_rd = 5'd7; wb_data = 32'h0000_0777;
        dec_rs1 = 5'd6; dec_rs1_used = 1'b1;
        settle();
        check("pass_we", 32'(rf_write_en), 32'd1);
        check("pass_wid", 32'(rf_write_id), 32'd7);
        check("pass_rid", 32'(rf_read1_id), 32'd6);
        tick();
        idle_inputs();

        // 1: debug write x5 with free write port.
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd5; dbg_wdata = 32'hDEAD_BEEF;
        settle();
        check("t1_we", 32'(rf_write_en), 32'd1);
        check("t1_wid", 32'(rf_write_id), 32'd5);
        check("t1_wdata", rf_write_data, 32'hDEAD_BEEF);
        tick();
        check("t1_ack", 32'(dbg_ack), 32'd1);
        check("t1_stall", 32'(stall_req), 32'd0);
        dbg_req = 1'b0;
        tick();
        check("t1_ack_clear", 32'(dbg_ack), 32'd0);

        // 2: debug read x7 blocked by decode for three cycles.
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd7;
        dec_rs1 = 5'd2; dec_rs1_used = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            check("t2_rid_blocked", 32'(rf_read1_id), 32'd2);
            check("t2_ack_wait", 32'(dbg_ack), 32'd0);
            tick();
        end
        dec_rs1_used = 1'b0;
        settle();
        check("t2_rid_grant", 32'(rf_read1_id), 32'd7);
        tick();
        check("t2_ack", 32'(dbg_ack), 32'd1);
        check("t2_rdata", dbg_rdata, 32'h0000_0777);
        check("t2_stall", 32'(stall_req), 32'd0);
        dbg_req = 1'b0;
        tick();

        // 3: continuous writeback forces a stall for a debug write of x9.
        wb_RegWrite = 1'b1; wb_rd = 5'd1; wb_data = 32'h0000_AAAA;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'h0000_0099;
        for (int c = 0; c < 13; c++) begin
            settle();
            check($sformatf("t3_stall_c%0d", c), 32'(stall_req), (c >= 9) ? 32'd1 : 32'd0);
            check($sformatf("t3_wid_c%0d", c), 32'(rf_write_id), (c == 12) ? 32'd9 : 32'd1);
            check($sformatf("t3_ack_c%0d", c), 32'(dbg_ack), 32'd0);
            tick();
        end
        check("t3_ack", 32'(dbg_ack), 32'd1);
        check("t3_stall_fall", 32'(stall_req), 32'd0);
        check("t3_x9", rf_mem[9], 32'h0000_0099);
        idle_inputs();
        tick();

        // 4: read x3 while writeback writes x3 in the same cycle.
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd3;
        wb_RegWrite = 1'b1; wb_rd = 5'd3; wb_data = 32'h0000_1234;
        tick();
        check("t4_ack", 32'(dbg_ack), 32'd1);
        check("t4_bypass", dbg_rdata, 32'h0000_1234);
        idle_inputs();
        tick();

        // 5: write x0 acks without a write; x0 reads back zero even if writeback targets it.
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd0; dbg_wdata = 32'hFFFF_FFFF;
        settle();
        check("t5_we", 32'(rf_write_en), 32'd0);
        tick();
        check("t5_ack", 32'(dbg_ack), 32'd1);
        dbg_req = 1'b0;
        tick();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd0;
        wb_RegWrite = 1'b1; wb_rd = 5'd0; wb_data = 32'h0000_5555;
        tick();
        check("t5_read_ack", 32'(dbg_ack), 32'd1);
        check("t5_read_x0", dbg_rdata, 32'd0);
        idle_inputs();
        tick();

        // 6: reset in STALL, then the held request is served normally.
        wb_RegWrite = 1'b1; wb_rd = 5'd1; wb_data = 32'h0000_AAAA;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'h0000_0066;
        for (int c = 0; c < 10; c++) tick();
        check("t6_in_stall", 32'(stall_req), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_stall", 32'(stall_req), 32'd0);
        check("t6_rst_ack", 32'(dbg_ack), 32'd0);
        wb_RegWrite = 1'b0;
        settle();
        check("t6_regrant_wid", 32'(rf_write_id), 32'd9);
        tick();
        check("t6_ack", 32'(dbg_ack), 32'd1);
        check("t6_x9", rf_mem[9], 32'h0000_0066);
        idle_inputs();
        tick();

        // Request dropped mid-wait: no ack and no stall.
        wb_RegWrite = 1'b1;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd4;
        tick();
        tick();
        dbg_req = 1'b0;
        tick();
        check("drop_ack", 32'(dbg_ack), 32'd0);
        check("drop_stall", 32'(stall_req), 32'd0);
        for (int c = 0; c < 10; c++) tick();
        check("drop_stall_late", 32'(stall_req), 32'd0);
        idle_inputs();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
